// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-byte ALU sequencer: state encoding,
// default operand width and byte-index width derivation.
package alu_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int NBYTES_DEF = 2;

  function automatic int calc_idxw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_seq_byte_counter.sv
// Byte index for the sequencer: clears to 0, advances by one when enabled,
// flags the final byte. Zero latency on the last-byte compare.
module alu_seq_byte_counter #(
  parameter int NBYTES = 2,
  parameter int IDXW   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  output logic [IDXW-1:0] idx,
  output logic            last
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
    end else if (en) begin
      idx <= idx + IDXW'(1);
    end
  end

  assign last = (idx == IDXW'(NBYTES - 1));

endmodule

// File: rtl/alu_multibyte_seq.sv
// Drives an 8-bit ALU over NBYTES operand bytes, LSB first; done pulses NBYTES+1 cycles after accept.
// start is only taken in IDLE (never queued); ALU_SEQ_OVERFLOW_EN adds a_msb/b_msb/flag_v.
module alu_multibyte_seq
  import alu_seq_pkg::*;
#(
  parameter int  NBYTES = NBYTES_DEF,
  localparam int IDXW   = calc_idxw(NBYTES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            op_sub,
  input  logic            cin_use,
  input  logic            flag_c_in,
  output logic            busy,
  output logic            done,
  output logic [IDXW-1:0] byte_idx,
  output logic            wr_en,
  output logic            alu_sub,
  output logic            alu_cin,
  input  logic            alu_cout,
  input  logic            alu_zero,
  input  logic            alu_msb,
`ifdef ALU_SEQ_OVERFLOW_EN
  input  logic            a_msb,
  input  logic            b_msb,
  output logic            flag_v,
`endif
  output logic            flag_z,
  output logic            flag_c,
  output logic            flag_n
);

  logic [1:0] state;
  logic       sub_q;
  logic       carry_q;
  logic       zacc_q;
  logic       accept;
  logic       in_run;
  logic       last;

  assign accept = (state == ST_IDLE) && start;
  assign in_run = (state == ST_RUN);

  // Index clears on accept and when leaving DONE, so it reads 0 throughout IDLE.
  alu_seq_byte_counter #(
    .NBYTES (NBYTES),
    .IDXW   (IDXW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept || (state == ST_DONE)),
    .en   (in_run && !last),
    .idx  (byte_idx),
    .last (last)
  );

  assign busy    = in_run;
  assign wr_en   = in_run;
  assign done    = (state == ST_DONE);
  assign alu_sub = sub_q;
  assign alu_cin = carry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b1;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_n  <= 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
      flag_v  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RUN;
            sub_q   <= op_sub;
            // Subtract is A + ~B + 1, so the implicit carry-in equals op_sub.
            carry_q <= cin_use ? flag_c_in : op_sub;
            zacc_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          carry_q <= alu_cout;
          zacc_q  <= zacc_q & alu_zero;
          if (last) begin
            state  <= ST_DONE;
            flag_z <= zacc_q & alu_zero;
            flag_c <= alu_cout;
            flag_n <= alu_msb;
`ifdef ALU_SEQ_OVERFLOW_EN
            flag_v <= (a_msb == (b_msb ^ sub_q)) & (alu_msb != a_msb);
`endif
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Table-driven bench for alu_multibyte_seq (NBYTES=2) with a behavioural 8-bit ALU and byte-wide destination.
module tb_alu_multibyte_seq;
  localparam int NB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, op_sub = 1'b0, cin_use = 1'b0, flag_c_in = 1'b0;
  logic busy, done, wr_en, alu_sub, alu_cin, alu_cout, alu_zero, alu_msb;
  logic [0:0] byte_idx;
  logic flag_z, flag_c, flag_n;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic a_msb, b_msb, flag_v;
`endif

  logic [15:0] opa = '0, opb = '0;
  logic [7:0]  a_byte, b_byte, alu_res;
  logic [8:0]  sum;
  logic [7:0]  dest [NB];
  logic        cin0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_multibyte_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .cin_use(cin_use),
    .flag_c_in(flag_c_in), .busy(busy), .done(done), .byte_idx(byte_idx),
    .wr_en(wr_en), .alu_sub(alu_sub), .alu_cin(alu_cin), .alu_cout(alu_cout),
    .alu_zero(alu_zero), .alu_msb(alu_msb),
`ifdef ALU_SEQ_OVERFLOW_EN
    .a_msb(a_msb), .b_msb(b_msb), .flag_v(flag_v),
`endif
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n)
  );

  // External ALU and register file byte ports
  assign a_byte   = byte_idx[0] ? opa[15:8] : opa[7:0];
  assign b_byte   = byte_idx[0] ? opb[15:8] : opb[7:0];
  assign sum      = {1'b0, a_byte} + {1'b0, (alu_sub ? ~b_byte : b_byte)} + {8'd0, alu_cin};
  assign alu_res  = sum[7:0];
  assign alu_cout = sum[8];
  assign alu_zero = (alu_res == 8'd0);
  assign alu_msb  = alu_res[7];
`ifdef ALU_SEQ_OVERFLOW_EN
  assign a_msb = opa[15];
  assign b_msb = opb[15];
`endif

  always @(posedge clk) begin
    if (wr_en) dest[byte_idx] <= alu_res;
    if (wr_en && byte_idx == 1'b0) cin0 <= alu_cin;
  end

  typedef struct {
    logic [15:0] a, b;
    logic        sub, cu, ci;
    logic [15:0] res;
    logic        z, c, n, v, cin0;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_flags(input vec_t v, input string tag);
    check({tag, " result"}, {16'd0, dest[1], dest[0]}, {16'd0, v.res});
    check({tag, " Z"}, {31'd0, flag_z}, {31'd0, v.z});
    check({tag, " C"}, {31'd0, flag_c}, {31'd0, v.c});
    check({tag, " N"}, {31'd0, flag_n}, {31'd0, v.n});
`ifdef ALU_SEQ_OVERFLOW_EN
    check({tag, " V"}, {31'd0, flag_v}, {31'd0, v.v});
`endif
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int cyc;
    @(negedge clk);
    opa = v.a; opb = v.b; op_sub = v.sub; cin_use = v.cu; flag_c_in = v.ci; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, " run busy/wr_en/idx"}, {29'd0, busy, wr_en, byte_idx}, 32'h6);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " done latency"}, cyc, NB + 1);
    check({tag, " done-cycle busy/wr_en"}, {30'd0, busy, wr_en}, 32'd0);
    check({tag, " cin byte0"}, {31'd0, cin0}, {31'd0, v.cin0});
    check_flags(v, tag);
  endtask

  initial begin
    int ndone;
    int done_cyc;
    //          a         b        sub   cu    ci    res       z     c     n     v     cin0
    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{16'h1234, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy/done/wr_en/idx", {28'd0, busy, done, wr_en, byte_idx}, 32'd0);
    check("reset flags", {29'd0, flag_z, flag_c, flag_n}, 32'd0);

    for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // start held through RUN and DONE, with op controls changed after accept
    @(negedge clk);
    opa = vecs[0].a; opb = vecs[0].b; op_sub = 1'b0; cin_use = 1'b0; flag_c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_sub = 1'b1; cin_use = 1'b1; flag_c_in = 1'b1;
    ndone = 0;
    done_cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      if (busy) check($sformatf("hold alu_sub c%0d", c), {31'd0, alu_sub}, 32'd0);
      if (done) begin
        ndone++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (c == 4) start = 1'b0;
      if (c == 3) check_flags(vecs[0], "hold");
      @(negedge clk);
    end
    check("hold done pulses", ndone, 1);
    check("hold done cycle", done_cyc, NB + 1);
    check_flags(vecs[0], "hold end");

    // reset during the first RUN cycle
    run_op(vecs[1], "pre-rst");
    @(negedge clk);
    opa = vecs[3].a; opb = vecs[3].b; op_sub = 1'b0; cin_use = 1'b1; flag_c_in = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("rst pre busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst busy/done/wr_en/idx", {28'd0, busy, done, wr_en, byte_idx}, 32'd0);
    check("rst flags", {29'd0, flag_z, flag_c, flag_n}, 32'd0);
`ifdef ALU_SEQ_OVERFLOW_EN
    check("rst V", {31'd0, flag_v}, 32'd0);
`endif
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    check("rst no activity", ndone, 0);
    run_op(vecs[3], "post-rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
